// File: rtl/store_narrow_rmw.sv
// Store narrowing unit: byte/half stores become read-modify-write on a word-only memory.
// Optional misalignment rejection is enabled by defining STORE_NARROW_ALIGN_CHECK_EN.
module store_narrow_rmw #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   input  logic [1:0]            req_size,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_rd_en,
   input  logic [31:0]           mem_rdata,
   input  logic                  mem_rvalid,
   output logic                  mem_wr_en,
   output logic [31:0]           mem_wdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_WRITE
`ifdef STORE_NARROW_ALIGN_CHECK_EN
      , S_ERROR
`endif
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [15:0]           wdata_q, wdata_d;
   logic                  half_q, half_d;
   logic [31:0]           buf_q, buf_d;
   logic [31:0]           merged;
   logic                  misaligned;

`ifdef STORE_NARROW_ALIGN_CHECK_EN
   assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                       (req_size[1] && (req_addr[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   // Little-endian lane insertion into the word read back from memory.
   always_comb begin
      merged = mem_rdata;
      if (half_q) begin
         if (addr_q[1]) merged[31:16] = wdata_q;
         else           merged[15:0]  = wdata_q;
      end else begin
         case (addr_q[1:0])
            2'd0:    merged[7:0]   = wdata_q[7:0];
            2'd1:    merged[15:8]  = wdata_q[7:0];
            2'd2:    merged[23:16] = wdata_q[7:0];
            default: merged[31:24] = wdata_q[7:0];
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      half_d  = half_q;
      buf_d   = buf_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               wdata_d = req_wdata[15:0];
               half_d  = (req_size == 2'b01);
               if (misaligned) begin
`ifdef STORE_NARROW_ALIGN_CHECK_EN
                  state_d = S_ERROR;
`endif
               end else if (req_size[1]) begin
                  buf_d   = req_wdata;
                  state_d = S_WRITE;
               end else begin
                  state_d = S_READ;
               end
            end
         end
         S_READ: state_d = S_WAIT;
         S_WAIT: begin
            if (mem_rvalid) begin
               buf_d   = merged;
               state_d = S_WRITE;
            end
         end
         S_WRITE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         half_q  <= 1'b0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         half_q  <= half_d;
         buf_q   <= buf_d;
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign mem_rd_en = (state_q == S_READ);
   assign mem_wr_en = (state_q == S_WRITE);
   assign done      = (state_q == S_WRITE);
   assign mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign mem_wdata = buf_q;
`ifdef STORE_NARROW_ALIGN_CHECK_EN
   assign err = (state_q == S_ERROR);
`else
   assign err = 1'b0;
`endif

endmodule

// File: doc/store_narrow_rmw.md
# store_narrow_rmw

Store-path narrowing unit for data memory: the counterpart of the immediate/load extend logic. Extension widens narrow values to 32 bits; this block narrows a 32-bit register value to byte or halfword and writes it into a word-only data memory. Sub-word stores use a read-modify-write sequence; word stores go straight through. It sits between the datapath store port and the data memory, handshaking with the control unit.

## Interface
- ADDR_WIDTH, 32, byte-address width; the word address is ADDR_WIDTH-2 bits, zero-padded into `mem_addr`.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  store request present
- req_ready  out  1  block can accept a request
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  register value; only the low 8/16 bits are used for sub-word stores
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- done  out  1  one-cycle pulse when the memory write issues
- err  out  1  one-cycle pulse on a rejected misaligned request
- mem_addr  out  ADDR_WIDTH  word-aligned address, {req_addr[ADDR_WIDTH-1:2], 2'b00}
- mem_rd_en  out  1  one-cycle read strobe
- mem_rdata  in  32  read data, valid only when `mem_rvalid` is high
- mem_rvalid  in  1  read data valid; latency ≥1 cycle after `mem_rd_en`
- mem_wr_en  out  1  one-cycle write strobe
- mem_wdata  out  32  full merged word

## Operation
- Reset value of every output except `req_ready` is 0. `req_ready` is 1. State is IDLE.
- Request capture:
  - A request is accepted when `req_valid && req_ready`.
  - Address, data and size are registered on acceptance.
  - `req_ready` is 1 only in IDLE.
- States and transitions:
  - IDLE → WRITE when the request is a word or reserved size.
  - IDLE → READ when the request is byte or half.
  - IDLE → ERROR when the request is misaligned (macro enabled only).
  - READ: asserts `mem_rd_en` for exactly one cycle, then → WAIT.
  - WAIT: holds until `mem_rvalid`. On `mem_rvalid`, the merged word is registered and the state goes to WRITE.
  - WRITE: asserts `mem_wr_en` and `done`, drives `mem_wdata` from the merge buffer, then → IDLE.
  - ERROR: asserts `err` for one cycle with no memory access, then → IDLE.
- Merge is little-endian.
  - Byte store: `wdata[7:0]` replaces lane `addr[1:0]` (bits 8k+7:8k). The other lanes keep their `mem_rdata` values.
  - Half store: `wdata[15:0]` replaces bits 31:16 when `addr[1]=1`, otherwise bits 15:0.
  - Word store: `mem_wdata = wdata`, with no read.
- `mem_addr` is held stable from acceptance through WRITE/ERROR.
- `mem_rvalid` outside WAIT is ignored.
- Reset asserted mid-operation: immediate return to IDLE, all strobes drop, and the in-flight store is abandoned (no partial write).

## Timing
- The request is accepted at edge N.
- Word store: `mem_wr_en`/`done` are high in cycle N+1. Throughput is one store per 2 cycles.
- Sub-word store:
  - `mem_rd_en` is high in cycle N+1.
  - The earliest `mem_rvalid` is in cycle N+2.
  - The write happens one cycle after `mem_rvalid`, so the minimum latency is N+3.
- Error: `err` is high in cycle N+1.
- `req_ready` falls the cycle after acceptance and rises the cycle after WRITE/ERROR.

## Configuration
- Macro `STORE_NARROW_ALIGN_CHECK_EN`.
- Defined:
  - Half with `addr[0]=1` → ERROR.
  - Word with `addr[1:0]≠0` → ERROR.
  - Bytes are never misaligned.
- Undefined:
  - No ERROR state; `err` is tied to 0.
  - Half ignores `addr[0]`; word ignores `addr[1:0]`. The store is aligned down silently.

## Test plan
- Reset check: assert `rst_n=0` mid-WAIT, then release → outputs 0, `req_ready=1`, no `mem_wr_en`; a late `mem_rvalid` is ignored.
- Word store: `addr=0x100`, `wdata=0xDEADBEEF`, size 10 → no read; `mem_wr_en` in N+1 with `mem_addr=0x100`, `mem_wdata=0xDEADBEEF`, `done=1`.
- Byte store: `addr=0x203`, `wdata=0x000000AB`, `mem_rdata=0x11223344` returned after a 3-cycle delay →
  - `mem_rd_en` with `mem_addr=0x200`;
  - write `0xAB223344` one cycle after `mem_rvalid`.
- Half store: `addr=0x302`, `wdata=0xFFFF5566`, `mem_rdata=0x11223344` → write `0x55663344`. With `addr=0x300` → write `0x11225566`.
- Misaligned half at `addr=0x401`:
  - With macro defined: `err` in N+1, no `mem_rd_en`/`mem_wr_en`.
  - Without macro: treated as `0x400`, writes the low half.
- Back-to-back: `req_valid` held high for 3 word stores → each accepted only when `req_ready=1`; exactly 3 `done` pulses, spaced 2 cycles apart.
